// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit select stage with a registered output and a two-entry skid buffer.
// Optional one-hot select with a sticky error flag is enabled by defining MUX_ONEHOT_SEL_EN.
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2,
    localparam int N = 2 ** SEL_W,
`ifdef MUX_ONEHOT_SEL_EN
    localparam int SW = 2 ** SEL_W
`else
    localparam int SW = SEL_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SW-1:0]      in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err
);

    logic             mainValid_q, mainValid_d;
    logic [WIDTH-1:0] mainData_q,  mainData_d;
    logic [SW-1:0]    mainSel_q,   mainSel_d;
    logic             skidValid_q, skidValid_d;
    logic [WIDTH-1:0] skidData_q,  skidData_d;
    logic [SW-1:0]    skidSel_q,   skidSel_d;
    logic [WIDTH-1:0] selData;
    logic             accept;

`ifdef MUX_ONEHOT_SEL_EN
    logic selBad;
    logic err_q, err_d;

    // A select that is not exactly one-hot still transfers, but as a zero word.
    always_comb begin
        selData = '0;
        selBad  = ($countones(in_sel) != 1);
        for (int k = 0; k < N; k++) begin
            if (in_sel[k]) begin
                selData = selData | in_data[k*WIDTH +: WIDTH];
            end
        end
        if (selBad) begin
            selData = '0;
        end
    end
`else
    always_comb begin
        selData = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SW'(k)) begin
                selData = in_data[k*WIDTH +: WIDTH];
            end
        end
    end
`endif

    // Skid drains into main before any new word is taken; in_ready is low while skid is full.
    always_comb begin
        mainValid_d = mainValid_q;
        mainData_d  = mainData_q;
        mainSel_d   = mainSel_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        skidSel_d   = skidSel_q;
        accept      = in_valid && !skidValid_q;
`ifdef MUX_ONEHOT_SEL_EN
        err_d       = err_q || (accept && selBad);
`endif
        if (!mainValid_q || out_ready) begin
            if (skidValid_q) begin
                mainValid_d = 1'b1;
                mainData_d  = skidData_q;
                mainSel_d   = skidSel_q;
                skidValid_d = 1'b0;
            end else if (accept) begin
                mainValid_d = 1'b1;
                mainData_d  = selData;
                mainSel_d   = in_sel;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (accept) begin
            skidValid_d = 1'b1;
            skidData_d  = selData;
            skidSel_d   = in_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mainValid_q <= 1'b0;
            mainData_q  <= '0;
            mainSel_q   <= '0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
            skidSel_q   <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            mainData_q  <= mainData_d;
            mainSel_q   <= mainSel_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            skidSel_q   <= skidSel_d;
        end
    end

`ifdef MUX_ONEHOT_SEL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = !skidValid_q;
    assign out_valid = mainValid_q;
    assign out_data  = mainData_q;
    assign out_sel   = mainSel_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: accepted words push expected results, a negedge monitor pops them.
// Reset, stall/skid, late select change and (with MUX_ONEHOT_SEL_EN) one-hot error cases are covered.
module tb_mux_n_pipe;

    localparam int WIDTH = 32;
    localparam int SEL_W = 2;
    localparam int N     = 2 ** SEL_W;
`ifdef MUX_ONEHOT_SEL_EN
    localparam int SW = N;
`else
    localparam int SW = SEL_W;
`endif

    localparam logic [WIDTH-1:0] W0 = 32'h11111111;
    localparam logic [WIDTH-1:0] W1 = 32'h22222222;
    localparam logic [WIDTH-1:0] W2 = 32'hAAAAAAAA;
    localparam logic [WIDTH-1:0] W3 = 32'hDEADBEEF;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    sel;
    } expEntry_t;

    logic               clk;
    logic               reset;
    logic [N*WIDTH-1:0] in_data;
    logic [SW-1:0]      in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;
    logic               err;

    expEntry_t sbQueue[$];
    int        checkCount = 0;
    int        passCount  = 0;

    mux_n_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] encodeSel(input int k);
`ifdef MUX_ONEHOT_SEL_EN
        return SW'(1) << k;
`else
        return SW'(k);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offers one word until accepted (bounded), then records its expected output.
    task automatic applyStimulus(input logic [SW-1:0] sel, input logic [WIDTH-1:0] expData,
                                 input logic [SW-1:0] expSel);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (acc) begin
            sbQueue.push_back('{data: expData, sel: expSel});
        end else begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The monitor compares every output transfer against the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnderflow", {out_data}, 32'hFFFFFFFF ^ out_data);
            end else begin
                expEntry_t e;
                e = sbQueue.pop_front();
                checkOutput("outData", out_data, e.data);
                checkOutput("outSel", WIDTH'(out_sel), WIDTH'(e.sel));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_data   = {W3, W2, W1, W0};
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset asserted mid-cycle clears a held word immediately.
        applyStimulus(encodeSel(3), W3, encodeSel(3));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstOutValid", WIDTH'(out_valid), 32'd0);
        checkOutput("rstOutData", out_data, 32'd0);
        checkOutput("rstInReady", WIDTH'(in_ready), 32'd1);
        checkOutput("rstErr", WIDTH'(err), 32'd0);
        sbQueue.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Back-to-back streaming.
        out_ready = 1'b1;
        applyStimulus(encodeSel(0), W0, encodeSel(0));
        applyStimulus(encodeSel(1), W1, encodeSel(1));
        applyStimulus(encodeSel(2), W2, encodeSel(2));
        applyStimulus(encodeSel(3), W3, encodeSel(3));
        idle(3);
        checkOutput("streamDrained", WIDTH'(sbQueue.size()), 32'd0);

        // Stall fills main then skid; release drains in order.
        out_ready = 1'b0;
        applyStimulus(encodeSel(3), W3, encodeSel(3));
        applyStimulus(encodeSel(1), W1, encodeSel(1));
        @(negedge clk);
        checkOutput("skidInReady", WIDTH'(in_ready), 32'd0);
        checkOutput("stallOutData", out_data, W3);
        checkOutput("stallOutSel", WIDTH'(out_sel), WIDTH'(encodeSel(3)));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("drainInReady", WIDTH'(in_ready), 32'd1);
        idle(2);

        // Select and data changes after accept do not disturb the stored word.
        out_ready = 1'b0;
        applyStimulus(encodeSel(2), W2, encodeSel(2));
        in_sel  = encodeSel(0);
        in_data = {W0, W1, W3, W3};
        repeat (3) @(negedge clk);
        checkOutput("heldOutData", out_data, W2);
        checkOutput("heldOutSel", WIDTH'(out_sel), WIDTH'(encodeSel(2)));
        in_data = {W3, W2, W1, W0};
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);

        // Reset with both entries full discards them; no stale word afterwards.
        out_ready = 1'b0;
        applyStimulus(encodeSel(3), W3, encodeSel(3));
        applyStimulus(encodeSel(1), W1, encodeSel(1));
        @(negedge clk);
        checkOutput("fullInReady", WIDTH'(in_ready), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRstOutValid", WIDTH'(out_valid), 32'd0);
        checkOutput("midRstOutData", out_data, 32'd0);
        checkOutput("midRstOutSel", WIDTH'(out_sel), 32'd0);
        checkOutput("midRstInReady", WIDTH'(in_ready), 32'd1);
        sbQueue.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(encodeSel(0), W0, encodeSel(0));
        idle(3);
        checkOutput("postRstIdle", WIDTH'(out_valid), 32'd0);

`ifdef MUX_ONEHOT_SEL_EN
        // Valid one-hot, then multi-hot which yields zero data and a sticky err.
        applyStimulus(4'b0100, W2, 4'b0100);
        @(negedge clk);
        checkOutput("oneHotErr", WIDTH'(err), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'b0110, 32'd0, 4'b0110);
        idle(4);
        checkOutput("multiHotErr", WIDTH'(err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("errCleared", WIDTH'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`else
        checkOutput("errTied", WIDTH'(err), 32'd0);
`endif

        checkOutput("sbEmpty", WIDTH'(sbQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
